// File: rtl/lfsr_gen.sv
// Parametrised LFSR with run-time seed load, step enable, all-zero lock-up recovery and period tracking.
// Define LFSR_GALOIS_EN to replace the default Fibonacci step with a Galois step.
module lfsr_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic [WIDTH-1:0] nxt_lfsr_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_lockup;
  logic [WIDTH-1:0] w_next;
  logic             w_seed_zero;
  logic             w_hit_seed;

`ifdef LFSR_GALOIS_EN
  assign w_next = {r_lfsr[WIDTH-2:0], 1'b0} ^ (r_lfsr[WIDTH-1] ? TAPS : '0);
`else
  logic w_fb;
  assign w_fb   = ^(r_lfsr & TAPS);
  assign w_next = {r_lfsr[WIDTH-2:0], w_fb};
`endif

  assign w_seed_zero = (seed_i == '0);
  // Period marker compares against the seed actually in use, not the parameter.
  assign w_hit_seed  = (w_next == r_seed);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_lfsr   <= SEED;
      r_seed   <= SEED;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else if (load) begin
      r_lfsr   <= seed_i;
      r_seed   <= seed_i;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_state  <= w_seed_zero ? ST_LOCKED : ST_RUN;
      r_lockup <= w_seed_zero;
    end else if (en) begin
      case (r_state)
        ST_RUN: begin
          r_lfsr <= w_next;
          if (w_hit_seed) begin
            r_wrap <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_wrap <= 1'b0;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Recovery restarts from the parameter seed without flagging a wrap.
          r_state  <= ST_RUN;
          r_lfsr   <= SEED;
          r_seed   <= SEED;
          r_cnt    <= '0;
          r_wrap   <= 1'b0;
          r_lockup <= 1'b0;
        end
        default: begin
          r_state  <= ST_RUN;
          r_lockup <= 1'b0;
          r_wrap   <= 1'b0;
        end
      endcase
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign lfsr_o     = r_lfsr;
  assign nxt_lfsr_o = w_next;
  assign cnt_o      = r_cnt;
  assign wrap_o     = r_wrap;
  assign lockup_o   = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen (default 4-bit parameters); expected sequences are hand tables.
module tb_lfsr_gen;
  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] seed_i;
  logic [3:0] lfsr_o;
  logic [3:0] nxt_lfsr_o;
  logic [3:0] cnt_o;
  logic       wrap_o;
  logic       lockup_o;

  int n_cmp;
  int n_bad;
  logic [3:0] seq [0:14];

  lfsr_gen dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .seed_i    (seed_i),
    .lfsr_o    (lfsr_o),
    .nxt_lfsr_o(nxt_lfsr_o),
    .cnt_o     (cnt_o),
    .wrap_o    (wrap_o),
    .lockup_o  (lockup_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    idx_of = 0;
    for (int k = 0; k < 15; k++)
      if (seq[k] == v) idx_of = k;
  endfunction

  initial begin
    int base;
    n_cmp = 0;
    n_bad = 0;
`ifdef LFSR_GALOIS_EN
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011, 4'b1111, 4'b0111,
            4'b1110, 4'b0101, 4'b1010, 4'b1101, 4'b0011, 4'b0110, 4'b1100};
`else
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
            4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000};
`endif
    reset = 1'b1; en = 1'b0; load = 1'b0; seed_i = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_lfsr", lfsr_o, 4'b0001);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_wrap", wrap_o, 0);
    chk("rst_lock", lockup_o, 0);
    chk("rst_nxt", nxt_lfsr_o, seq[1]);

    // Full period from reset seed
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("seq_lfsr%0d", i), lfsr_o, seq[(i + 1) % 15]);
      chk($sformatf("seq_cnt%0d", i), cnt_o, (i < 14) ? i + 1 : 0);
      chk($sformatf("seq_wrap%0d", i), wrap_o, (i == 14) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk("idle_wrap", wrap_o, 0);
    chk("idle_lfsr", lfsr_o, 4'b0001);

    // Run-time seed 1011
    load = 1'b1; seed_i = 4'b1011;
    tick();
    load = 1'b0;
    chk("ld_lfsr", lfsr_o, 4'b1011);
    chk("ld_cnt", cnt_o, 0);
    chk("ld_wrap", wrap_o, 0);
    base = idx_of(4'b1011);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("ld_seq%0d", i), lfsr_o, seq[(base + i + 1) % 15]);
      chk($sformatf("ld_wrap%0d", i), wrap_o, (i == 14) ? 1 : 0);
      chk($sformatf("ld_cnt%0d", i), cnt_o, (i < 14) ? i + 1 : 0);
    end
    en = 1'b0;

    // Lock-up and recovery
    load = 1'b1; seed_i = 4'b0000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lk_lock", lockup_o, 1);
      chk("lk_lfsr", lfsr_o, 4'b0000);
      chk("lk_nxt", nxt_lfsr_o, 4'b0000);
      tick();
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("rec_lfsr", lfsr_o, 4'b0001);
    chk("rec_lock", lockup_o, 0);
    chk("rec_cnt", cnt_o, 0);
    chk("rec_wrap", wrap_o, 0);

    // load beats en; then en 1-0-1
    load = 1'b1; en = 1'b1; seed_i = 4'b0110;
    tick();
    load = 1'b0;
    chk("le_lfsr", lfsr_o, 4'b0110);
    chk("le_cnt", cnt_o, 0);
    base = idx_of(4'b0110);
    tick();
    chk("t1_lfsr", lfsr_o, seq[(base + 1) % 15]);
    chk("t1_cnt", cnt_o, 1);
    en = 1'b0;
    tick();
    chk("t0_lfsr", lfsr_o, seq[(base + 1) % 15]);
    chk("t0_cnt", cnt_o, 1);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("t2_lfsr", lfsr_o, seq[(base + 2) % 15]);
    chk("t2_cnt", cnt_o, 2);
    chk("t2_wrap", wrap_o, 0);

    // Reset mid-sequence wins over en and load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_lfsr", lfsr_o, seq[7]);
    chk("pre_cnt", cnt_o, 7);
    reset = 1'b1; load = 1'b1; seed_i = 4'b0000;
    tick();
    reset = 1'b0; load = 1'b0; en = 1'b0;
    chk("mr_lfsr", lfsr_o, 4'b0001);
    chk("mr_cnt", cnt_o, 0);
    chk("mr_wrap", wrap_o, 0);
    chk("mr_lock", lockup_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
